// File: rtl/text_pkg.sv
// Shared constants for the character-buffer text path.
// Holds the blank/dot character codes and the buffer FSM state encoding.
// Imported by the character buffer and its helpers.
package text_pkg;

    localparam logic [6:0] FILL_CODE = 7'h20;
    localparam logic [6:0] DOT_CODE  = 7'h2E;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/char_anim_ctr.sv
// Frame-tick divider feeding the "waiting dots" phase counter.
// Latency: dot_phase updates on the clock edge that samples frame_tick.
// No backpressure; both counters are forced to zero while anim_en is low.
module char_anim_ctr #(
    parameter int TICK_DIV = 30,
    parameter int DOTS_MAX = 3,
    localparam int PW = $clog2(DOTS_MAX + 1),
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          anim_en,
    input  logic          frame_tick,
    output logic [PW-1:0] dot_phase
);

    logic [TW-1:0] tick_cnt_q;
    logic [PW-1:0] dot_phase_q;

    // Divide frame ticks down to animation steps and cycle the phase 0..DOTS_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            dot_phase_q <= '0;
        end else if (!anim_en) begin
            tick_cnt_q  <= '0;
            dot_phase_q <= '0;
        end else if (frame_tick) begin
            if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
                tick_cnt_q  <= '0;
                dot_phase_q <= (dot_phase_q == PW'(DOTS_MAX)) ? '0 : dot_phase_q + 1'b1;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
        end
    end

    assign dot_phase = dot_phase_q;

endmodule

// File: rtl/char_buf_anim.sv
// Writable COLS x ROWS character buffer with fill sequencer and animated dot overlay.
// Latency: read address to char_code_out is 2 cycles, fully pipelined.
// Backpressure: wr_ready is low for the whole clear sequence; reads are never stalled.
module char_buf_anim
    import text_pkg::*;
#(
    parameter int COLS     = 16,
    parameter int ROWS     = 16,
    parameter int CODE_W   = 7,
    parameter int TICK_DIV = 30,
    parameter int DOTS_MAX = 3,
    parameter int ANIM_ROW = 0,
    parameter int ANIM_COL = 8,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int AW = RW + CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     char_xy,
    output logic [CODE_W-1:0] char_code_out,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              busy,
    input  logic              anim_en,
    input  logic              frame_tick
);

    localparam int DEPTH = COLS * ROWS;
    localparam int PW    = $clog2(DOTS_MAX + 1);

    localparam logic [CW:0]       ANIM_COL_X = (CW + 1)'(ANIM_COL);
    localparam logic [CW:0]       ANIM_END_X = (CW + 1)'(ANIM_COL + DOTS_MAX);
    localparam logic [RW-1:0]     ANIM_ROW_X = RW'(ANIM_ROW);
    localparam logic [CODE_W-1:0] FILL_X     = CODE_W'(FILL_CODE);
    localparam logic [CODE_W-1:0] DOT_X      = CODE_W'(DOT_CODE);

    buf_state_t        state_q;
    logic [AW-1:0]     clr_addr_q;
    logic              busy_q;
    logic              wr_ready_q;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [CODE_W-1:0] mem_wdata;

    logic [PW-1:0]     dot_phase;

    logic [CODE_W-1:0] rd_q;
    logic              ovl_hit_d, ovl_hit_q;
    logic              ovl_dot_d, ovl_dot_q;
    logic [CW:0]       col_x;
    logic [CW:0]       col_off;
    logic [CODE_W-1:0] char_code_d, char_code_q;

    char_anim_ctr #(
        .TICK_DIV (TICK_DIV),
        .DOTS_MAX (DOTS_MAX)
    ) u_anim_ctr (
        .clk        (clk),
        .rst        (rst),
        .anim_en    (anim_en),
        .frame_tick (frame_tick),
        .dot_phase  (dot_phase)
    );

    // Clear sweeps every address once, then the buffer accepts host writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_addr_q == AW'(DEPTH - 1)) begin
                        state_q    <= IDLE;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_start) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= CLEAR;
                    clr_addr_q <= '0;
                    busy_q     <= 1'b1;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Single write port is shared: the sweep owns it while clearing, the host otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = FILL_X;
        end else if (wr_en && wr_ready_q) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; contents are deliberately left unreset and filled by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Decide in the address cycle whether the dot overlay owns this cell.
    always_comb begin
        col_x     = {1'b0, char_xy[CW-1:0]};
        col_off   = col_x - ANIM_COL_X;
        ovl_hit_d = 1'b0;
        ovl_dot_d = 1'b0;
        if (anim_en && (char_xy[AW-1:CW] == ANIM_ROW_X) &&
            (col_x >= ANIM_COL_X) && (col_x < ANIM_END_X)) begin
            ovl_hit_d = 1'b1;
            ovl_dot_d = (col_off < (CW + 1)'(dot_phase));
        end
    end

    // First read stage: read-first RAM access plus the registered overlay decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q      <= '0;
            ovl_hit_q <= 1'b0;
            ovl_dot_q <= 1'b0;
        end else begin
            rd_q      <= mem_q[char_xy];
            ovl_hit_q <= ovl_hit_d;
            ovl_dot_q <= ovl_dot_d;
        end
    end

    assign char_code_d = ovl_hit_q ? (ovl_dot_q ? DOT_X : FILL_X) : rd_q;

    // Second read stage: select overlay or stored code into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_code_q <= '0;
        end else begin
            char_code_q <= char_code_d;
        end
    end

    assign char_code_out = char_code_q;
    assign busy          = busy_q;
    assign wr_ready      = wr_ready_q;

endmodule

// File: tb/tb_char_buf_anim.sv
module tb_char_buf_anim;

    localparam int AW = 8;
    localparam int N  = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_xy = '0;
    logic [6:0] char_code_out;
    logic       wr_en = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_addr = '0;
    logic [6:0] wr_data = '0;
    logic       clr_start = 1'b0;
    logic       busy;
    logic       anim_en = 1'b0;
    logic       frame_tick = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] addr;
        logic [6:0] exp;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    rd_exp_t mon_e;

    logic rd_vld = 1'b0;
    logic v1 = 1'b0;
    logic v2 = 1'b0;

    char_buf_anim #(
        .COLS     (16),
        .ROWS     (16),
        .CODE_W   (7),
        .TICK_DIV (2),
        .DOTS_MAX (3),
        .ANIM_ROW (0),
        .ANIM_COL (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .char_xy       (char_xy),
        .char_code_out (char_code_out),
        .wr_en         (wr_en),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .clr_start     (clr_start),
        .busy          (busy),
        .anim_en       (anim_en),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    // Bench-side tracker of read issue so the monitor knows when data is due.
    always @(posedge clk) begin
        v1 <= rd_vld;
        v2 <= v1;
    end

    // Monitor: pop expected read data when a read reaches the output.
    always @(negedge clk) begin
        if (v2) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected: got %h with no expected entry", char_code_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (char_code_out !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL read addr=%h: got %h expected %h", mon_e.addr, char_code_out, mon_e.exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [6:0] e);
        rd_exp_t t;
        t.addr  = a;
        t.exp   = e;
        char_xy = a;
        rd_vld  = 1'b1;
        exp_q.push_back(t);
        step();
        rd_vld = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [6:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            step();
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic busy_cycles(output int c);
        c = 0;
        while (busy === 1'b1 && c < 1000) begin
            step();
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [6:0] msg [8];
        rd_exp_t t;
        msg[0] = 7'h57; msg[1] = 7'h41; msg[2] = 7'h49; msg[3] = 7'h54;
        msg[4] = 7'h49; msg[5] = 7'h4E; msg[6] = 7'h47; msg[7] = 7'h2E;

        // Reset defaults.
        repeat (3) step();
        check("rst_char_code", char_code_out, 0);
        check("rst_busy", busy, 1);
        check("rst_wr_ready", wr_ready, 0);
        rst = 1'b0;
        busy_cycles(c);
        check("init_clear_cycles", c, N);
        check("init_wr_ready", wr_ready, 1);
        for (int a = 0; a < N; a++) rd(8'(a), 7'h20);
        drain();

        // Write then read, and read-first collision.
        wr(8'h00, 7'h57);
        rd(8'h00, 7'h57);
        wr_en = 1'b1; wr_addr = 8'h01; wr_data = 7'h41;
        char_xy = 8'h01; rd_vld = 1'b1;
        t.addr = 8'h01; t.exp = 7'h20; exp_q.push_back(t);
        step();
        wr_en = 1'b0; rd_vld = 1'b0;
        rd(8'h01, 7'h41);
        drain();

        // Fill "WAITING." then clear, with writes attempted while busy.
        for (int i = 0; i < 8; i++) wr(8'(i), msg[i]);
        for (int i = 0; i < 8; i++) rd(8'(i), msg[i]);
        drain();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("clr_busy_rise", busy, 1);
        check("clr_wr_ready", wr_ready, 0);
        wr_en = 1'b1; wr_addr = 8'h00; wr_data = 7'h7F;
        busy_cycles(c);
        wr_en = 1'b0;
        check("clr_cycles", c, N);
        for (int a = 0; a < N; a++) rd(8'(a), 7'h20);
        drain();

        // Overlay precedence and animation with TICK_DIV=2.
        wr(8'h08, 7'h58); wr(8'h09, 7'h41); wr(8'h0a, 7'h59);
        wr(8'h0b, 7'h42); wr(8'h18, 7'h5A);
        anim_en = 1'b1;
        rd(8'h08, 7'h20); rd(8'h09, 7'h20); rd(8'h0a, 7'h20);
        rd(8'h0b, 7'h42); rd(8'h18, 7'h5A);
        drain();
        tick(); tick();
        rd(8'h08, 7'h2E); rd(8'h09, 7'h20); rd(8'h0a, 7'h20);
        drain();
        repeat (4) tick();
        rd(8'h08, 7'h2E); rd(8'h09, 7'h2E); rd(8'h0a, 7'h2E);
        drain();
        repeat (2) tick();
        rd(8'h08, 7'h20); rd(8'h09, 7'h20); rd(8'h0a, 7'h20);
        drain();
        // Phase changes on the same edge the address is sampled: old phase wins.
        tick();
        char_xy = 8'h08; rd_vld = 1'b1; frame_tick = 1'b1;
        t.addr = 8'h08; t.exp = 7'h20; exp_q.push_back(t);
        step();
        rd_vld = 1'b0; frame_tick = 1'b0;
        rd(8'h08, 7'h2E);
        drain();
        anim_en = 1'b0;
        rd(8'h08, 7'h58); rd(8'h09, 7'h41); rd(8'h0a, 7'h59);
        drain();
        anim_en = 1'b1;
        rd(8'h08, 7'h20);
        drain();
        anim_en = 1'b0;

        // Reset in the middle of a clear sweep.
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        #1;
        check("midrst_char_code", char_code_out, 0);
        check("midrst_busy", busy, 1);
        check("midrst_wr_ready", wr_ready, 0);
        step(); step();
        rst = 1'b0;
        busy_cycles(c);
        check("midrst_clear_cycles", c, N);
        rd(8'h00, 7'h20); rd(8'h09, 7'h20); rd(8'h18, 7'h20); rd(8'hFF, 7'h20);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
